// File: rtl/spinnaker_fpgas_sync_chain.sv
// Multi-bit, multi-stage flip-flop synchroniser into the CLK_IN domain.
// Each bit is synchronised independently, so the source must be Gray-coded or quasi-static.
module spinnaker_fpgas_sync_chain #(
  parameter int              SIZE      = 1,
  parameter int              STAGES    = 2,
  parameter logic [SIZE-1:0] RESET_VAL = '0
) (
  input  logic            CLK_IN,
  input  logic            RESET_IN,
  input  logic [SIZE-1:0] IN,
  output logic [SIZE-1:0] OUT
);

  generate
    if (SIZE < 1) begin : g_bad_size
      $error("spinnaker_fpgas_sync_chain: SIZE must be >= 1");
    end
    if (STAGES < 2) begin : g_bad_stages
      $error("spinnaker_fpgas_sync_chain: STAGES must be >= 2");
    end
  endgenerate

  // Stage 0 feeds only stage 1, so a metastable capture gets a full period to resolve.
  (* ASYNC_REG = "TRUE" *) logic [SIZE-1:0] sync_p [STAGES];

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_p[k] <= RESET_VAL;
      end
    end else begin
      sync_p[0] <= IN;
      for (int k = 1; k < STAGES; k++) begin
        sync_p[k] <= sync_p[k-1];
      end
    end
  end

  assign OUT = sync_p[STAGES-1];

endmodule

// File: tb/tb_spinnaker_fpgas_sync_chain.sv
// Randomised scoreboard bench: three synchroniser configurations share clock, reset and input;
// each expected output is the input value applied STAGES-1 edges earlier (or the reset value).
module tb_spinnaker_fpgas_sync_chain;

  logic       CLK_IN = 1'b0;
  logic       RESET_IN;
  logic [1:0] in_v;
  logic [1:0] out_a, out_b, out_c;

  localparam logic [1:0] RV_A = 2'b00;
  localparam logic [1:0] RV_B = 2'b00;
  localparam logic [1:0] RV_C = 2'b10;
  localparam int         ST_A = 2;
  localparam int         ST_B = 3;
  localparam int         ST_C = 2;

  always #5 CLK_IN = ~CLK_IN;

  spinnaker_fpgas_sync_chain #(.SIZE(2), .STAGES(ST_A), .RESET_VAL(RV_A)) dut_a (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .IN(in_v), .OUT(out_a));
  spinnaker_fpgas_sync_chain #(.SIZE(2), .STAGES(ST_B), .RESET_VAL(RV_B)) dut_b (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .IN(in_v), .OUT(out_b));
  spinnaker_fpgas_sync_chain #(.SIZE(2), .STAGES(ST_C), .RESET_VAL(RV_C)) dut_c (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .IN(in_v), .OUT(out_c));

  logic [1:0] qa[$], qb[$], qc[$];
  bit         mon_en = 1'b0;
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic underflow(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t: scoreboard empty when output sampled", nm, $time);
  endtask

  // Monitor: the output is valid every cycle, so pop one expectation per edge per DUT.
  initial begin
    forever begin
      @(posedge CLK_IN);
      #1;
      if (mon_en) begin
        if (qa.size() == 0) underflow("out_a"); else chk("out_a", out_a, qa.pop_front());
        if (qb.size() == 0) underflow("out_b"); else chk("out_b", out_b, qb.pop_front());
        if (qc.size() == 0) underflow("out_c"); else chk("out_c", out_c, qc.pop_front());
      end
    end
  end

  // Apply one value for the coming edge and record it as a future expected output.
  task automatic step(input logic [1:0] v);
    @(negedge CLK_IN);
    in_v = v;
    qa.push_back(v);
    qb.push_back(v);
    qc.push_back(v);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_a"}, out_a, RV_A);
    chk({nm, "_b"}, out_b, RV_B);
    chk({nm, "_c"}, out_c, RV_C);
  endtask

  // Assert reset between edges, verify it acts without a clock, hold a few edges.
  task automatic do_reset(input logic [1:0] in_during);
    @(negedge CLK_IN);
    #2;
    mon_en   = 1'b0;
    RESET_IN = 1'b0;
    in_v     = in_during;
    #1;
    check_reset_vals("async_rst");
    qa.delete();
    qb.delete();
    qc.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK_IN);
      #1;
      in_v = 2'(($urandom_range(0, 3)));
      check_reset_vals("hold_rst");
    end
  endtask

  // Release reset at a falling edge; the following rising edge captures v into stage 0.
  task automatic do_release(input logic [1:0] v);
    @(negedge CLK_IN);
    RESET_IN = 1'b1;
    for (int i = 0; i < ST_A - 1; i++) qa.push_back(RV_A);
    for (int i = 0; i < ST_B - 1; i++) qb.push_back(RV_B);
    for (int i = 0; i < ST_C - 1; i++) qc.push_back(RV_C);
    in_v = v;
    qa.push_back(v);
    qb.push_back(v);
    qc.push_back(v);
    mon_en = 1'b1;
  endtask

  logic [1:0] cur;
  logic [1:0] gray_seq [4];

  initial begin
    RESET_IN = 1'b1;
    in_v     = 2'b11;
    #1;
    RESET_IN = 1'b0;
    #1;
    check_reset_vals("init_rst");
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK_IN);
      #1;
      check_reset_vals("rst_in11");
    end

    // Latency: 00 held, then 00 -> 01.
    do_release(2'b00);
    step(2'b00);
    step(2'b00);
    step(2'b01);
    step(2'b01);
    step(2'b01);

    // Gray walk, each value held two cycles.
    gray_seq[0] = 2'b11;
    gray_seq[1] = 2'b10;
    gray_seq[2] = 2'b00;
    gray_seq[3] = 2'b01;
    for (int r = 0; r < 2; r++) begin
      for (int g = 0; g < 4; g++) begin
        step(gray_seq[g]);
        step(gray_seq[g]);
      end
    end

    // Random single-bit flips with random hold lengths.
    cur = in_v;
    for (int i = 0; i < 150; i++) begin
      cur[$urandom_range(0, 1)] ^= 1'b1;
      for (int h = 0; h < int'($urandom_range(1, 3)); h++) step(cur);
    end

    // Mid-stream reset while OUT is 11.
    for (int i = 0; i < 4; i++) step(2'b11);
    @(posedge CLK_IN);
    #2;
    chk("pre_rst_a", out_a, 2'b11);
    chk("pre_rst_c", out_c, 2'b11);
    do_reset(2'b10);
    do_release(2'b10);
    step(2'b10);
    step(2'b10);

    // Release with 00 so the 10 reset value of dut_c is overwritten.
    do_reset(2'b00);
    do_release(2'b00);
    step(2'b00);
    step(2'b00);

    // Arbitrary random values every cycle.
    for (int i = 0; i < 150; i++) step(2'($urandom_range(0, 3)));
    for (int i = 0; i < 4; i++) step(in_v);

    @(posedge CLK_IN);
    #2;
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got no summary expected summary");
    $fatal(1, "timeout");
  end

endmodule
